// File: rtl/ex_muldiv_hilo_if.sv
// Execute-stage multiply/divide and HI/LO access bundle.
// master: the ID/EX side that presents operands and control.
// slave:  the multiply/divide unit that owns HI/LO and drives stall.
interface ex_muldiv_hilo_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] ex_A;
    logic [XLEN-1:0] ex_B;
    logic            op_valid;
    logic [1:0]      op;
    logic [1:0]      ex_whilo;
    logic [XLEN-1:0] ex_wdata;
    logic            flush;
    logic            stall;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output ex_A, ex_B, op_valid, op, ex_whilo, ex_wdata, flush,
        input  stall, hi, lo
    );

    modport slave (
        input  ex_A, ex_B, op_valid, op, ex_whilo, ex_wdata, flush,
        output stall, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes on acceptance, processed by 32 restoring
// divide or shift-add multiply steps, then sign-corrected in FIX, which writes
// HI/LO. Stall holds the front of the pipe until the result is committed.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle product and
// go straight from IDLE to FIX (divide timing unchanged).
module ex_muldiv_hilo #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    ex_muldiv_hilo_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q,   state_d;
    logic [4:0]      counter_q, counter_d;
    logic [XLEN-1:0] acc_hi_q,  acc_hi_d;   // remainder / product high half
    logic [XLEN-1:0] acc_lo_q,  acc_lo_d;   // dividend->quotient / multiplier->product low
    logic [XLEN-1:0] opnd_b_q,  opnd_b_d;   // divisor magnitude or multiplicand magnitude
    logic            is_div_q,  is_div_d;
    logic            sign_a_q,  sign_a_d;
    logic            sign_b_q,  sign_b_d;
    logic [XLEN-1:0] hi_q,      hi_d;
    logic [XLEN-1:0] lo_q,      lo_d;
    logic            stall;

    // Operand magnitudes; op[0]==0 selects the signed forms.
    logic            op_signed;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    // One iteration of each algorithm, computed from the accumulator.
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   rem_diff;
    logic [XLEN:0]   mul_sum;

    // Sign-corrected results presented to HI/LO during FIX.
    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;

    logic            mt_allowed;

    // Datapath helpers: magnitudes, single algorithm steps and sign fixup.
    always_comb begin
        op_signed = ~bus.op[0];
        abs_a     = (op_signed && bus.ex_A[XLEN-1]) ? -bus.ex_A : bus.ex_A;
        abs_b     = (op_signed && bus.ex_B[XLEN-1]) ? -bus.ex_B : bus.ex_B;

        rem_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        rem_diff  = rem_shift - {1'b0, opnd_b_q};
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_b_q} : {(XLEN+1){1'b0}});

        prod_raw  = {acc_hi_q, acc_lo_q};
        prod_fix  = (sign_a_q ^ sign_b_q) ? -prod_raw : prod_raw;
        quot_fix  = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
        rem_fix   = sign_a_q ? -acc_hi_q : acc_hi_q;
    end

    // Control FSM, iteration datapath and HI/LO update.
    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_b_d   = opnd_b_q;
        is_div_d   = is_div_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        stall      = 1'b0;
        // MTHI/MTLO only when no mul/div is being accepted and nothing is killed.
        mt_allowed = ~bus.op_valid & ~bus.flush;

        case (state_q)
            S_IDLE: begin
                if (bus.op_valid && !bus.flush) begin
                    stall     = 1'b1;
                    is_div_d  = bus.op[1];
                    sign_a_d  = op_signed & bus.ex_A[XLEN-1];
                    sign_b_d  = op_signed & bus.ex_B[XLEN-1];
                    opnd_b_d  = abs_b;
                    counter_d = 5'd0;
                    acc_hi_d  = '0;
                    acc_lo_d  = abs_a;
                    state_d   = S_ITER;
`ifdef MULDIV_FAST_MUL_EN
                    // Multiplies bypass iteration: the full product lands now.
                    if (!bus.op[1]) begin
                        {acc_hi_d, acc_lo_d} = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
                        state_d              = S_FIX;
                    end
`endif
                end else if (mt_allowed) begin
                    if (bus.ex_whilo[1]) hi_d = bus.ex_wdata;
                    if (bus.ex_whilo[0]) lo_d = bus.ex_wdata;
                end
            end

            S_ITER: begin
                stall = 1'b1;
                if (bus.flush) begin
                    state_d   = S_IDLE;
                    counter_d = 5'd0;
                end else begin
                    if (is_div_q) begin
                        // Restoring step: keep the trial difference when non-negative.
                        if (!rem_diff[XLEN]) begin
                            acc_hi_d = rem_diff[XLEN-1:0];
                            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b1};
                        end else begin
                            acc_hi_d = rem_shift[XLEN-1:0];
                            acc_lo_d = {acc_lo_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        // Shift-add step: conditional add, then shift the 65-bit pair right.
                        acc_hi_d = mul_sum[XLEN:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[XLEN-1:1]};
                    end
                    if (counter_q == 5'd31) begin
                        counter_d = 5'd0;
                        state_d   = S_FIX;
                    end else begin
                        counter_d = counter_q + 5'd1;
                    end
                end
            end

            S_FIX: begin
                stall = 1'b1;
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end else begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // The finishing instruction is still in EX; op_valid is not a new request.
                state_d = S_IDLE;
                if (mt_allowed) begin
                    if (bus.ex_whilo[1]) hi_d = bus.ex_wdata;
                    if (bus.ex_whilo[0]) lo_d = bus.ex_wdata;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and architectural register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            counter_q <= 5'd0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opnd_b_q  <= '0;
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_b_q  <= opnd_b_d;
            is_div_q  <= is_div_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Output drive.
    always_comb begin
        bus.stall = stall;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// Directed bench for ex_muldiv_hilo with a HI/LO scoreboard and latency checks.
// Build with MULDIV_FAST_MUL_EN defined to check the fast-multiply timing.
module tb_ex_muldiv_hilo;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    localparam int DIV_LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ex_muldiv_hilo_if bus_if ();

    ex_muldiv_hilo #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.hi  = hi;
        e.lo  = lo;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it against the visible HI/LO.
    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = sb.pop_front();
            chk({e.tag, " hi"}, bus_if.hi, e.hi);
            chk({e.tag, " lo"}, bus_if.lo, e.lo);
            $display("txn %s hi=%h lo=%h", e.tag, bus_if.hi, bus_if.lo);
        end
    endtask

    // Issue one mul/div at a drive point, hold op_valid until stall drops,
    // then confirm the held instruction is not re-issued from DONE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int elat);
        int cycles;
        push_exp(tag, eh, el);
        bus_if.op_valid = 1'b1;
        bus_if.op       = op;
        bus_if.ex_A     = a;
        bus_if.ex_B     = b;
        cycles          = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus_if.stall) break;
            cycles++;
            step();
        end
        chk({tag, " latency"}, cycles, elat);
        pop_check();
        step();
        bus_if.op_valid = 1'b0;
        @(negedge clk);
        chk({tag, " no reissue stall"}, {31'd0, bus_if.stall}, 32'd0);
        chk({tag, " hold hi"}, bus_if.hi, eh);
        step();
    endtask

    task automatic mt_write(input logic [1:0] whilo, input logic [31:0] data);
        bus_if.ex_whilo = whilo;
        bus_if.ex_wdata = data;
        step();
        bus_if.ex_whilo = 2'b00;
    endtask

    initial begin
        logic [31:0] ra, rb, eh, el;
        logic [63:0] p;
        int          cycles;

        reset           = 1'b1;
        bus_if.ex_A     = '0;
        bus_if.ex_B     = '0;
        bus_if.op_valid = 1'b0;
        bus_if.op       = 2'b00;
        bus_if.ex_whilo = 2'b00;
        bus_if.ex_wdata = '0;
        bus_if.flush    = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Reset state.
        push_exp("reset", 32'h0, 32'h0);
        @(negedge clk);
        chk("reset stall", {31'd0, bus_if.stall}, 32'd0);
        pop_check();
        step();

        // Directed arithmetic cases.
        run_op("divu_100_7",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT);
        run_op("div_m7_2",    OP_DIV,   32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  DIV_LAT);
        run_op("div_min_m1",  OP_DIV,   32'h80000000,  32'hFFFFFFFF,  32'h0,         32'h80000000,  DIV_LAT);
        run_op("mult_m2_3",   OP_MULT,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  32'hFFFFFFFA,  MUL_LAT);
        run_op("multu_m2_3",  OP_MULTU, 32'hFFFFFFFE,  32'd3,         32'h2,         32'hFFFFFFFA,  MUL_LAT);
        run_op("divu_by0",    OP_DIVU,  32'h12345678,  32'h0,         32'h12345678,  32'hFFFFFFFF,  DIV_LAT);
        run_op("div_m5_by0",  OP_DIV,   32'hFFFFFFFB,  32'h0,         32'hFFFFFFFB,  32'h00000001,  DIV_LAT);

        // Unsigned cases checked against the simulator's own arithmetic.
        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom;
            p  = {32'd0, ra} * {32'd0, rb};
            run_op("multu_rand", OP_MULTU, ra, rb, p[63:32], p[31:0], MUL_LAT);
            rb = $urandom_range(1, 65535);
            run_op("divu_rand", OP_DIVU, ra, rb, ra % rb, ra / rb, DIV_LAT);
        end

        // MTHI/MTLO both halves in IDLE.
        mt_write(2'b11, 32'hA5A5A5A5);
        push_exp("mt_a5", 32'hA5A5A5A5, 32'hA5A5A5A5);
        @(negedge clk);
        pop_check();
        step();

        // Flush mid-divide leaves preloaded HI/LO intact.
        mt_write(2'b11, 32'h55);
        bus_if.op_valid = 1'b1;
        bus_if.op       = OP_DIVU;
        bus_if.ex_A     = 32'd100;
        bus_if.ex_B     = 32'd7;
        repeat (10) step();
        bus_if.flush = 1'b1;
        @(negedge clk);
        chk("flush T+10 stall", {31'd0, bus_if.stall}, 32'd1);
        step();
        bus_if.flush    = 1'b0;
        bus_if.op_valid = 1'b0;
        push_exp("flush_abort", 32'h55, 32'h55);
        @(negedge clk);
        chk("flush T+11 stall", {31'd0, bus_if.stall}, 32'd0);
        pop_check();
        step();

        // Reset mid-divide clears HI/LO.
        mt_write(2'b11, 32'h55);
        bus_if.op_valid = 1'b1;
        repeat (10) step();
        reset = 1'b1;
        step();
        reset           = 1'b0;
        bus_if.op_valid = 1'b0;
        push_exp("reset_abort", 32'h0, 32'h0);
        @(negedge clk);
        chk("reset T+11 stall", {31'd0, bus_if.stall}, 32'd0);
        pop_check();
        step();

        // op_valid outranks ex_whilo in the same cycle.
        push_exp("opv_wins", 32'd2, 32'd14);
        bus_if.op_valid = 1'b1;
        bus_if.op       = OP_DIVU;
        bus_if.ex_A     = 32'd100;
        bus_if.ex_B     = 32'd7;
        bus_if.ex_whilo = 2'b11;
        bus_if.ex_wdata = 32'hA5A5A5A5;
        step();
        bus_if.ex_whilo = 2'b00;
        @(negedge clk);
        chk("opv_wins T+1 hi", bus_if.hi, 32'h0);
        chk("opv_wins T+1 stall", {31'd0, bus_if.stall}, 32'd1);
        cycles = 2;
        for (int i = 0; i < 100; i++) begin
            step();
            @(negedge clk);
            if (!bus_if.stall) break;
            cycles++;
        end
        chk("opv_wins latency", cycles, DIV_LAT);
        pop_check();
        step();
        bus_if.op_valid = 1'b0;
        step();

        // Flush in IDLE blocks both acceptance and MTHI/MTLO.
        bus_if.op_valid = 1'b1;
        bus_if.flush    = 1'b1;
        bus_if.ex_whilo = 2'b11;
        bus_if.ex_wdata = 32'h77;
        @(negedge clk);
        chk("idle_flush stall", {31'd0, bus_if.stall}, 32'd0);
        step();
        bus_if.op_valid = 1'b0;
        bus_if.flush    = 1'b0;
        bus_if.ex_whilo = 2'b00;
        push_exp("idle_flush", 32'd2, 32'd14);
        @(negedge clk);
        chk("idle_flush next stall", {31'd0, bus_if.stall}, 32'd0);
        pop_check();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
